// File: rtl/mem_req_arbiter.sv
// Arbitrates ICache and DCache miss requests onto a single-transaction SRAM engine.
// Holds the granted request stable, cancels flushed I fills, and bounds ICache starvation.
//
// state | meaning
// IDLE  | no transaction; selects D or I for the next grant
// GNT_I | I request presented to engine, waiting for mem_ready_i
// GNT_D | D request presented to engine, waiting for mem_ready_d
// COOL  | one dead cycle for engine ready-clear and requester req-drop
module mem_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_ack,
  output logic [LINE_W-1:0] icache_line,
  input  logic              dcache_req,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [31:0]       dcache_wdata,
  output logic              dcache_ack,
  output logic [LINE_W-1:0] dcache_line,
  output logic              mem_valid_i,
  output logic [ADDR_W-1:0] mem_inst_addr,
  output logic              mem_valid_d,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_data_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_ready_d,
  input  logic [LINE_W-1:0] mem_line_d,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, COOL} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                cancel_q, cancel_d;
  logic                valid_i_q, valid_i_d;
  logic                valid_d_q, valid_d_d;
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
  logic                store_q, store_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                iack_q, iack_d;
  logic                dack_q, dack_d;
  logic [LINE_W-1:0]   iline_q, iline_d;
  logic [LINE_W-1:0]   dline_q, dline_d;
  logic                busy_q;
  logic                sel_d, sel_i;

  // D wins unless the I side has already lost STARVE_LIMIT times in a row.
  assign sel_d = dcache_req && !(icache_req && (starve_cnt_q == LIMIT));
  assign sel_i = !sel_d && icache_req && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      cancel_q     <= 1'b0;
      valid_i_q    <= 1'b0;
      valid_d_q    <= 1'b0;
      inst_addr_q  <= '0;
      data_addr_q  <= '0;
      store_q      <= 1'b0;
      wdata_q      <= '0;
      iack_q       <= 1'b0;
      dack_q       <= 1'b0;
      iline_q      <= '0;
      dline_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      cancel_q     <= cancel_d;
      valid_i_q    <= valid_i_d;
      valid_d_q    <= valid_d_d;
      inst_addr_q  <= inst_addr_d;
      data_addr_q  <= data_addr_d;
      store_q      <= store_d;
      wdata_q      <= wdata_d;
      iack_q       <= iack_d;
      dack_q       <= dack_d;
      iline_q      <= iline_d;
      dline_q      <= dline_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_d)      state_d = GNT_D;
        else if (sel_i) state_d = GNT_I;
      end
      GNT_I:   if (mem_ready_i) state_d = COOL;
      GNT_D:   if (mem_ready_d) state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    cancel_d     = cancel_q;
    valid_i_d    = valid_i_q;
    valid_d_d    = valid_d_q;
    inst_addr_d  = inst_addr_q;
    data_addr_d  = data_addr_q;
    store_d      = store_q;
    wdata_d      = wdata_q;
    iack_d       = 1'b0;
    dack_d       = 1'b0;
    iline_d      = iline_q;
    dline_d      = dline_q;
    case (state_q)
      IDLE: begin
        if (sel_d) begin
          valid_d_d   = 1'b1;
          data_addr_d = dcache_addr;
          store_d     = dcache_we;
          wdata_d     = dcache_wdata;
          if (!icache_req)                starve_cnt_d = '0;
          else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (sel_i) begin
          valid_i_d    = 1'b1;
          inst_addr_d  = icache_addr;
          starve_cnt_d = '0;
        end
      end
      GNT_I: begin
        // The engine burst cannot be aborted, so a flush only suppresses the ack.
        if (flush) cancel_d = 1'b1;
        if (mem_ready_i) begin
          valid_i_d = 1'b0;
          cancel_d  = 1'b0;
          if (!cancel_q && !flush) begin
            iack_d  = 1'b1;
            iline_d = mem_line_i;
          end
        end
      end
      GNT_D: begin
        if (mem_ready_d) begin
          valid_d_d = 1'b0;
          dack_d    = 1'b1;
          dline_d   = mem_line_d;
        end
      end
      default: ;
    endcase
  end

  assign icache_ack    = iack_q;
  assign icache_line   = iline_q;
  assign dcache_ack    = dack_q;
  assign dcache_line   = dline_q;
  assign mem_valid_i   = valid_i_q;
  assign mem_inst_addr = inst_addr_q;
  assign mem_valid_d   = valid_d_q;
  assign mem_store     = store_q;
  assign mem_data_addr = data_addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: grants and acks are predicted in order and
// checked by a negedge monitor; an engine model answers requests after eng_lat cycles.
module tb_mem_req_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         icache_req = 1'b0;
  logic [31:0]  icache_addr = '0;
  logic         icache_ack;
  logic [127:0] icache_line;
  logic         dcache_req = 1'b0;
  logic         dcache_we = 1'b0;
  logic [31:0]  dcache_addr = '0;
  logic [31:0]  dcache_wdata = '0;
  logic         dcache_ack;
  logic [127:0] dcache_line;
  logic         mem_valid_i;
  logic [31:0]  mem_inst_addr;
  logic         mem_valid_d;
  logic         mem_store;
  logic [31:0]  mem_data_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready_i = 1'b0;
  logic [127:0] mem_line_i;
  logic         mem_ready_d = 1'b0;
  logic [127:0] mem_line_d;
  logic         busy;

  mem_req_arbiter #(.ADDR_W(32), .LINE_W(128), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ack(icache_ack), .icache_line(icache_line),
    .dcache_req(dcache_req), .dcache_we(dcache_we), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_ack(dcache_ack), .dcache_line(dcache_line),
    .mem_valid_i(mem_valid_i), .mem_inst_addr(mem_inst_addr),
    .mem_valid_d(mem_valid_d), .mem_store(mem_store), .mem_data_addr(mem_data_addr),
    .mem_wdata(mem_wdata), .mem_ready_i(mem_ready_i), .mem_line_i(mem_line_i),
    .mem_ready_d(mem_ready_d), .mem_line_d(mem_line_d), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_i; logic [31:0] addr; bit store; logic [31:0] wdata; } grant_t;
  typedef struct { bit is_i; logic [127:0] line; } ack_t;

  grant_t exp_grant[$];
  ack_t   exp_ack[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;
  int     last_i_rise = 0;
  int     last_d_rise = 0;

  function automatic logic [127:0] line_fn(bit is_i, logic [31:0] a);
    if (is_i) return {a, ~a, a ^ 32'h1111_1111, a + 32'd7};
    return {a + 32'd3, a ^ 32'hFFFF_0000, ~a, a};
  endfunction

  assign mem_line_i = line_fn(1'b1, mem_inst_addr);
  assign mem_line_d = line_fn(1'b0, mem_data_addr);

  // Engine model: one-cycle ready pulse after eng_lat negedges of valid.
  int eng_lat = 1;
  bit eng_en = 1'b1;
  int eng_cnt = 0;
  always @(negedge clk) begin
    if (mem_ready_i || mem_ready_d) begin
      mem_ready_i = 1'b0;
      mem_ready_d = 1'b0;
      eng_cnt = 0;
    end else if (eng_en && (mem_valid_i === 1'b1 || mem_valid_d === 1'b1)) begin
      eng_cnt++;
      if (eng_cnt >= eng_lat) begin
        if (mem_valid_i === 1'b1) mem_ready_i = 1'b1;
        else mem_ready_d = 1'b1;
        eng_cnt = 0;
      end
    end else if (!(mem_valid_i === 1'b1 || mem_valid_d === 1'b1)) begin
      eng_cnt = 0;
    end
  end

  logic prev_vi = 1'b0, prev_vd = 1'b0, prev_ia = 1'b0, prev_da = 1'b0;
  always @(negedge clk) begin : monitor
    grant_t g;
    ack_t a;
    cyc++;
    if (mon_en) begin
      vectors++;
      if (mem_valid_i === 1'b1 && mem_valid_d === 1'b1) begin
        miscompares++;
        $display("FAIL valid_overlap: mem_valid_i=%b mem_valid_d=%b, required at most one high", mem_valid_i, mem_valid_d);
      end
      if (mem_valid_i === 1'b1 && !prev_vi) begin
        last_i_rise = cyc;
        vectors++;
        if (exp_grant.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_i_grant: addr=%h, required no grant", mem_inst_addr);
        end else begin
          g = exp_grant.pop_front();
          if (!g.is_i || mem_inst_addr !== g.addr) begin
            miscompares++;
            $display("FAIL i_grant: side=I addr=%h, required side=%s addr=%h", mem_inst_addr, g.is_i ? "I" : "D", g.addr);
          end
        end
      end
      if (mem_valid_d === 1'b1 && !prev_vd) begin
        last_d_rise = cyc;
        vectors++;
        if (exp_grant.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_d_grant: addr=%h, required no grant", mem_data_addr);
        end else begin
          g = exp_grant.pop_front();
          if (g.is_i || mem_data_addr !== g.addr || mem_store !== g.store || mem_wdata !== g.wdata) begin
            miscompares++;
            $display("FAIL d_grant: side=D addr=%h store=%b wdata=%h, required side=%s addr=%h store=%b wdata=%h",
                     mem_data_addr, mem_store, mem_wdata, g.is_i ? "I" : "D", g.addr, g.store, g.wdata);
          end
        end
      end
      if (icache_ack === 1'b1) begin
        vectors++;
        if (prev_ia) begin
          miscompares++;
          $display("FAIL i_ack_pulse: icache_ack high 2 cycles, required 1");
        end else if (exp_ack.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_i_ack: line=%h, required no ack", icache_line);
        end else begin
          a = exp_ack.pop_front();
          if (!a.is_i || icache_line !== a.line) begin
            miscompares++;
            $display("FAIL i_ack: side=I line=%h, required side=%s line=%h", icache_line, a.is_i ? "I" : "D", a.line);
          end
        end
      end
      if (dcache_ack === 1'b1) begin
        vectors++;
        if (prev_da) begin
          miscompares++;
          $display("FAIL d_ack_pulse: dcache_ack high 2 cycles, required 1");
        end else if (exp_ack.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_d_ack: line=%h, required no ack", dcache_line);
        end else begin
          a = exp_ack.pop_front();
          if (a.is_i || dcache_line !== a.line) begin
            miscompares++;
            $display("FAIL d_ack: side=D line=%h, required side=%s line=%h", dcache_line, a.is_i ? "I" : "D", a.line);
          end
        end
      end
      prev_vi = (mem_valid_i === 1'b1);
      prev_vd = (mem_valid_d === 1'b1);
      prev_ia = (icache_ack === 1'b1);
      prev_da = (dcache_ack === 1'b1);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({icache_ack, dcache_ack, mem_valid_i, mem_valid_d, mem_store, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 000000", {icache_ack, dcache_ack, mem_valid_i, mem_valid_d, mem_store, busy});
    end
    vectors++;
    if ({icache_line, dcache_line, mem_inst_addr, mem_data_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, required 0", {icache_line, dcache_line, mem_inst_addr, mem_data_addr, mem_wdata});
    end
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || mem_valid_i !== 1'b0 || mem_valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: busy=%b vi=%b vd=%b, required 0 0 0", busy, mem_valid_i, mem_valid_d);
    end
  endtask

  task automatic test_i_only();
    int ack_n = -1;
    eng_lat = 20;
    exp_grant.push_back('{1'b1, 32'h8000_0040, 1'b0, 32'h0});
    exp_ack.push_back('{1'b1, line_fn(1'b1, 32'h8000_0040)});
    icache_addr = 32'h8000_0040;
    icache_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_valid_i !== 1'b1 || mem_inst_addr !== 32'h8000_0040) begin
      miscompares++;
      $display("FAIL i_valid_latency: valid=%b addr=%h, required 1 80000040", mem_valid_i, mem_inst_addr);
    end
    for (int n = 0; n < 40 && ack_n < 0; n++) begin
      @(negedge clk);
      if (icache_ack === 1'b1) ack_n = n;
    end
    icache_req = 1'b0;
    vectors++;
    if (ack_n != 19) begin
      miscompares++;
      $display("FAIL i_ack_latency: ack at loop cycle %0d, required 19", ack_n);
    end
    vectors++;
    if (busy !== 1'b1 || mem_valid_i !== 1'b0) begin
      miscompares++;
      $display("FAIL i_cool: busy=%b valid_i=%b, required 1 0", busy, mem_valid_i);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || icache_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL i_idle: busy=%b ack=%b, required 0 0", busy, icache_ack);
    end
  endtask

  task automatic test_simultaneous();
    bit done = 1'b0;
    eng_lat = 1;
    exp_grant.push_back('{1'b0, 32'h8040_0010, 1'b1, 32'hDEAD_BEEF});
    exp_grant.push_back('{1'b1, 32'h8000_0080, 1'b0, 32'h0});
    exp_ack.push_back('{1'b0, line_fn(1'b0, 32'h8040_0010)});
    exp_ack.push_back('{1'b1, line_fn(1'b1, 32'h8000_0080)});
    dcache_addr = 32'h8040_0010;
    dcache_we = 1'b1;
    dcache_wdata = 32'hDEAD_BEEF;
    icache_addr = 32'h8000_0080;
    dcache_req = 1'b1;
    icache_req = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (dcache_ack === 1'b1) dcache_req = 1'b0;
      if (icache_ack === 1'b1) begin
        icache_req = 1'b0;
        done = 1'b1;
      end
    end
    dcache_req = 1'b0;
    icache_req = 1'b0;
    dcache_we = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL simul_timeout: I ack not seen, required within 40 cycles");
    end
    vectors++;
    if (last_i_rise - last_d_rise != 3) begin
      miscompares++;
      $display("FAIL b2b_gap: I rise - D rise = %0d cycles, required 3", last_i_rise - last_d_rise);
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int d_done = 0;
    bit i_done = 1'b0;
    bit reissue = 1'b0;
    eng_lat = 1;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) begin
        exp_grant.push_back('{1'b1, 32'h8000_0200, 1'b0, 32'h0});
        exp_ack.push_back('{1'b1, line_fn(1'b1, 32'h8000_0200)});
      end
      exp_grant.push_back('{1'b0, 32'h4000_0000 + 32'(n * 16), n[0], 32'h1000 + 32'(n)});
      exp_ack.push_back('{1'b0, line_fn(1'b0, 32'h4000_0000 + 32'(n * 16))});
    end
    dcache_addr = 32'h4000_0000;
    dcache_we = 1'b0;
    dcache_wdata = 32'h1000;
    icache_addr = 32'h8000_0200;
    dcache_req = 1'b1;
    icache_req = 1'b1;
    for (int n = 0; n < 200 && !(d_done == 6 && i_done); n++) begin
      @(negedge clk);
      if (dcache_ack === 1'b1) begin
        dcache_req = 1'b0;
        d_done++;
        reissue = (d_done < 6);
      end else if (reissue) begin
        dcache_addr = 32'h4000_0000 + 32'(d_done * 16);
        dcache_we = d_done[0];
        dcache_wdata = 32'h1000 + 32'(d_done);
        dcache_req = 1'b1;
        reissue = 1'b0;
      end
      if (icache_ack === 1'b1) begin
        icache_req = 1'b0;
        i_done = 1'b1;
      end
    end
    dcache_req = 1'b0;
    icache_req = 1'b0;
    vectors++;
    if (d_done != 6 || !i_done) begin
      miscompares++;
      $display("FAIL starve_timeout: d_done=%0d i_done=%0d, required 6 1", d_done, i_done);
    end
    @(negedge clk);
    vectors++;
    if (dut.starve_cnt_q !== '0) begin
      miscompares++;
      $display("FAIL starve_cnt_clear: starve_cnt=%0d, required 0", dut.starve_cnt_q);
    end
  endtask

  task automatic test_flush_fill();
    int hi_cnt = 0;
    bit got = 1'b0;
    eng_lat = 12;
    exp_grant.push_back('{1'b1, 32'h8000_0100, 1'b0, 32'h0});
    exp_grant.push_back('{1'b1, 32'h8000_1000, 1'b0, 32'h0});
    exp_ack.push_back('{1'b1, line_fn(1'b1, 32'h8000_1000)});
    icache_addr = 32'h8000_0100;
    icache_req = 1'b1;
    for (int n = 0; n < 10 && hi_cnt == 0; n++) begin
      @(negedge clk);
      if (mem_valid_i === 1'b1) hi_cnt = 1;
    end
    repeat (5) begin
      @(negedge clk);
      if (mem_valid_i === 1'b1) hi_cnt++;
    end
    flush = 1'b1;
    @(negedge clk);
    if (mem_valid_i === 1'b1) hi_cnt++;
    flush = 1'b0;
    icache_addr = 32'h8000_1000;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (mem_valid_i !== 1'b1) break;
      hi_cnt++;
      vectors++;
      if (mem_inst_addr !== 32'h8000_0100 || icache_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_hold: addr=%h ack=%b, required 80000100 0", mem_inst_addr, icache_ack);
      end
    end
    vectors++;
    if (icache_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cancel_ack: icache_ack=%b at completion, required 0", icache_ack);
    end
    vectors++;
    if (hi_cnt != 12) begin
      miscompares++;
      $display("FAIL flush_valid_len: mem_valid_i high %0d cycles, required 12", hi_cnt);
    end
    eng_lat = 3;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (icache_ack === 1'b1) got = 1'b1;
    end
    icache_req = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL flush_reissue_timeout: no ack for 80001000, required within 40 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_flush_idle();
    bit got = 1'b0;
    eng_lat = 2;
    exp_grant.push_back('{1'b1, 32'h8000_2000, 1'b0, 32'h0});
    exp_ack.push_back('{1'b1, line_fn(1'b1, 32'h8000_2000)});
    icache_addr = 32'h8000_2000;
    icache_req = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (mem_valid_i !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_block: valid_i=%b busy=%b, required 0 0", mem_valid_i, busy);
    end
    @(negedge clk);
    vectors++;
    if (mem_valid_i !== 1'b1 || mem_inst_addr !== 32'h8000_2000) begin
      miscompares++;
      $display("FAIL flush_idle_grant: valid_i=%b addr=%h, required 1 80002000", mem_valid_i, mem_inst_addr);
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (icache_ack === 1'b1) got = 1'b1;
    end
    icache_req = 1'b0;
    @(negedge clk);
    // D is still eligible while flush is high.
    got = 1'b0;
    exp_grant.push_back('{1'b0, 32'h4000_0800, 1'b0, 32'h0000_0055});
    exp_ack.push_back('{1'b0, line_fn(1'b0, 32'h4000_0800)});
    dcache_addr = 32'h4000_0800;
    dcache_we = 1'b0;
    dcache_wdata = 32'h0000_0055;
    dcache_req = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (mem_valid_d !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_d_grant: valid_d=%b, required 1", mem_valid_d);
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (dcache_ack === 1'b1) got = 1'b1;
    end
    dcache_req = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL flush_d_timeout: no dcache_ack, required within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_d();
    bit seen = 1'b0;
    eng_en = 1'b0;
    exp_grant.push_back('{1'b0, 32'h4444_0000, 1'b0, 32'h0BAD_F00D});
    dcache_addr = 32'h4444_0000;
    dcache_we = 1'b0;
    dcache_wdata = 32'h0BAD_F00D;
    dcache_req = 1'b1;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (mem_valid_d === 1'b1) seen = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dcache_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({icache_ack, dcache_ack, mem_valid_i, mem_valid_d, mem_store, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL midrst_flags: got %b, required 000000", {icache_ack, dcache_ack, mem_valid_i, mem_valid_d, mem_store, busy});
    end
    vectors++;
    if ({icache_line, dcache_line, mem_inst_addr, mem_data_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL midrst_data: got %h, required 0", {icache_line, dcache_line, mem_inst_addr, mem_data_addr, mem_wdata});
    end
    rst = 1'b0;
    eng_en = 1'b1;
    eng_lat = 2;
    repeat (3) @(negedge clk);
    seen = 1'b0;
    exp_grant.push_back('{1'b0, 32'h4444_0100, 1'b1, 32'h0000_1234});
    exp_ack.push_back('{1'b0, line_fn(1'b0, 32'h4444_0100)});
    dcache_addr = 32'h4444_0100;
    dcache_we = 1'b1;
    dcache_wdata = 32'h0000_1234;
    dcache_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_valid_d !== 1'b1 || mem_store !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_regrant: valid_d=%b store=%b, required 1 1", mem_valid_d, mem_store);
    end
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (dcache_ack === 1'b1) seen = 1'b1;
    end
    dcache_req = 1'b0;
    dcache_we = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_starvation();
    test_flush_fill();
    test_flush_idle();
    test_reset_mid_d();
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_grant.size() != 0 || exp_ack.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d grants %0d acks outstanding, required 0 0", exp_grant.size(), exp_ack.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
